encoder_position_tracker: RTL

ENCODER_POSITION_TRACKER -- requirements
Module: encoder_position_tracker

---
 rtl/enc_pkg.sv | 25 ++
 rtl/enc_window_timer.sv | 28 ++
 rtl/encoder_position_tracker.sv | 114 +++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Step-code constants and helpers shared by the quadrature decoder and the position tracker.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package enc_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_IDLE    = 2'b00;
  localparam dir_t DIR_POS     = 2'b01;
  localparam dir_t DIR_NEG     = 2'b10;
  localparam dir_t DIR_ILLEGAL = 2'b11;

  // Map a step code to a 2-bit two's-complement increment (+1, -1 or 0).
  // The illegal code contributes no motion.
  function automatic logic [1:0] dir_to_step(input dir_t d);
    logic [1:0] s;
    case (d)
      DIR_POS: s = 2'b01;
      DIR_NEG: s = 2'b11;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/enc_window_timer.sv
// Free-running window counter 0..WINDOW_CYCLES-1; tick marks the last cycle of each window.
// Latency: tick is combinational from the counter; the first tick falls WINDOW_CYCLES-1 cycles after reset release.
// Backpressure: none; the counter always advances.
module enc_window_timer #(
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: advance, wrapping to zero after the terminal count.
  always_comb begin
    tick  = (cnt_q == CNT_W'(WINDOW_CYCLES - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter register; reset puts the window back at its first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/encoder_position_tracker.sv
// Accumulates quadrature steps into a signed position and reports net steps per fixed window as velocity.
// Latency: position, err and overflow one cycle after the sampled step; velocity/vel_valid one cycle after the window's last cycle.
// Backpressure: none; a step is consumed every cycle. Macro ENC_POS_SATURATE_EN selects clamping instead of wrapping position.
module encoder_position_tracker
  import enc_pkg::*;
#(
  parameter int POS_WIDTH     = 16,
  parameter int VEL_WIDTH     = 12,
  parameter int WINDOW_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  dir,
  input  logic                        clear,
  output logic signed [POS_WIDTH-1:0] position,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        vel_valid,
  output logic                        err,
  output logic                        overflow
);

  localparam logic [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [VEL_WIDTH-1:0] sum_q, sum_d;
  logic [VEL_WIDTH-1:0] vel_q, vel_d;
  logic                 vel_valid_q, vel_valid_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;

  logic [1:0]           step;
  logic [POS_WIDTH:0]   pos_ext;
  logic                 pos_ovf;
  logic [VEL_WIDTH:0]   sum_ext;
  logic [VEL_WIDTH-1:0] sum_sat;
  logic                 tick;

  enc_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_window_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Decode the step and form one-bit-wider sums so signed overflow is visible.
  always_comb begin
    step    = dir_to_step(dir);
    pos_ext = {pos_q[POS_WIDTH-1], pos_q} + {{(POS_WIDTH-1){step[1]}}, step};
    pos_ovf = pos_ext[POS_WIDTH] != pos_ext[POS_WIDTH-1];
    sum_ext = {sum_q[VEL_WIDTH-1], sum_q} + {{(VEL_WIDTH-1){step[1]}}, step};
    if (sum_ext[VEL_WIDTH] != sum_ext[VEL_WIDTH-1])
      sum_sat = sum_ext[VEL_WIDTH] ? VEL_MIN : VEL_MAX;
    else
      sum_sat = sum_ext[VEL_WIDTH-1:0];
  end

  // Position and sticky overflow; clear wins over a same-cycle step.
  always_comb begin
    pos_d = pos_ext[POS_WIDTH-1:0];
    ovf_d = ovf_q;
    if (clear) begin
      pos_d = '0;
      ovf_d = 1'b0;
    end else if (pos_ovf) begin
      ovf_d = 1'b1;
`ifdef ENC_POS_SATURATE_EN
      pos_d = pos_q;
`else
      pos_d = pos_ext[POS_WIDTH-1:0];
`endif
    end
  end

  // Window sum keeps counting through clear; at the terminal count it is published and restarted.
  always_comb begin
    sum_d       = sum_sat;
    vel_d       = vel_q;
    vel_valid_d = 1'b0;
    err_d       = (dir == DIR_ILLEGAL);
    if (tick) begin
      vel_d       = sum_sat;
      vel_valid_d = 1'b1;
      sum_d       = '0;
    end
  end

  // State registers; reset clears every output immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q       <= '0;
      sum_q       <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      sum_q       <= sum_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign position  = pos_q;
  assign velocity  = vel_q;
  assign vel_valid = vel_valid_q;
  assign err       = err_q;
  assign overflow  = ovf_q;

endmodule
